cdb_arbiter: RTL and testbench

Writeback arbiter between the three functional units (ALU, branch, memory) and the single common data bus (CDB) feeding the PRF, ROB completion and RS wakeup. Each FU result is captured into a per-source FIFO. One result per cycle is granted onto a registered CDB. Entries younger than a resolved mispredict are squashed in place, so wrong-path results never broadcast.

---
 rtl/cdb_arbiter_if.sv | 53 +++++
 rtl/cdb_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Writeback bus between the three functional units, the ROB age reference and the CDB.
// master = FU/ROB side driving results, slave = the cdb_arbiter.
interface cdb_arbiter_if #(
    parameter int ROB_W  = 5,
    parameter int PREG_W = 7
);
    logic              alu_valid;
    logic [ROB_W-1:0]  alu_rob_tag;
    logic [PREG_W-1:0] alu_pd;
    logic [31:0]       alu_data;
    logic              alu_full;

    logic              b_valid;
    logic [ROB_W-1:0]  b_rob_tag;
    logic [PREG_W-1:0] b_pd;
    logic [31:0]       b_data;
    logic              b_full;

    logic              mem_valid;
    logic [ROB_W-1:0]  mem_rob_tag;
    logic [PREG_W-1:0] mem_pd;
    logic [31:0]       mem_data;
    logic              mem_full;

    logic [ROB_W-1:0]  rob_head;
    logic              mispredict;
    logic [ROB_W-1:0]  mispredict_tag;

    logic              cdb_valid;
    logic [ROB_W-1:0]  cdb_rob_tag;
    logic [PREG_W-1:0] cdb_pd;
    logic [31:0]       cdb_data;
    logic [1:0]        cdb_src;
    logic              overflow;

    modport master (
        output alu_valid, alu_rob_tag, alu_pd, alu_data,
        output b_valid, b_rob_tag, b_pd, b_data,
        output mem_valid, mem_rob_tag, mem_pd, mem_data,
        output rob_head, mispredict, mispredict_tag,
        input  alu_full, b_full, mem_full,
        input  cdb_valid, cdb_rob_tag, cdb_pd, cdb_data, cdb_src, overflow
    );

    modport slave (
        input  alu_valid, alu_rob_tag, alu_pd, alu_data,
        input  b_valid, b_rob_tag, b_pd, b_data,
        input  mem_valid, mem_rob_tag, mem_pd, mem_data,
        input  rob_head, mispredict, mispredict_tag,
        output alu_full, b_full, mem_full,
        output cdb_valid, cdb_rob_tag, cdb_pd, cdb_data, cdb_src, overflow
    );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB writeback arbiter: per-FU result FIFOs with in-place mispredict squash and a registered CDB.
// Define CDB_OLDEST_FIRST_EN to grant the oldest candidate instead of round-robin.
module cdb_arbiter #(
    parameter int DEPTH  = 4,
    parameter int ROB_W  = 5,
    parameter int PREG_W = 7
) (
    input  logic         clk,
    input  logic         reset,
    cdb_arbiter_if.slave bus
);
    localparam int NSRC  = 3;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_MEM = 2'd2;

    typedef struct packed {
        logic [ROB_W-1:0]  rob_tag;
        logic [PREG_W-1:0] pd;
        logic [31:0]       data;
    } result_t;

    function automatic logic [ROB_W-1:0] age_of(input logic [ROB_W-1:0] tag,
                                                input logic [ROB_W-1:0] head);
        return ROB_W'(tag - head);
    endfunction

    // Storage and state
    result_t           payload_q [NSRC][DEPTH];
    logic [DEPTH-1:0]  valid_q   [NSRC];
    logic [PTR_W-1:0]  rd_ptr_q  [NSRC];
    logic [PTR_W-1:0]  wr_ptr_q  [NSRC];
    logic [CNT_W-1:0]  count_q   [NSRC];
    logic [NSRC-1:0]   full_q;
    logic [1:0]        last_grant_q;
    logic              cdb_valid_q;
    result_t           cdb_res_q;
    logic [1:0]        cdb_src_q;
    logic              overflow_q;

    // Combinational view of this cycle
    logic              in_valid  [NSRC];
    result_t           in_res    [NSRC];
    result_t           head_res  [NSRC];
    logic [DEPTH-1:0]  kill      [NSRC];
    logic [DEPTH-1:0]  valid_nxt [NSRC];
    logic [CNT_W-1:0]  count_nxt [NSRC];
    logic [NSRC-1:0]   cand, pop_inv, deq, accept;
    logic [ROB_W-1:0]  mp_age;
    logic              ovf_hit;
    logic              grant_any;
    logic [1:0]        grant_src;
`ifdef CDB_OLDEST_FIRST_EN
    logic [ROB_W-1:0]  best_age;
`else
    logic [1:0]        rr_idx;
`endif

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        in_valid[0] = bus.alu_valid;
        in_valid[1] = bus.b_valid;
        in_valid[2] = bus.mem_valid;
        in_res[0]   = '{rob_tag: bus.alu_rob_tag, pd: bus.alu_pd, data: bus.alu_data};
        in_res[1]   = '{rob_tag: bus.b_rob_tag,   pd: bus.b_pd,   data: bus.b_data};
        in_res[2]   = '{rob_tag: bus.mem_rob_tag, pd: bus.mem_pd, data: bus.mem_data};
        mp_age      = age_of(bus.mispredict_tag, bus.rob_head);
        cand        = '0;
        pop_inv     = '0;
        deq         = '0;
        accept      = '0;
        ovf_hit     = 1'b0;
        grant_any   = 1'b0;
        grant_src   = SRC_ALU;

        for (int s = 0; s < NSRC; s++) begin
            kill[s]     = '0;
            head_res[s] = payload_q[s][rd_ptr_q[s]];
            // Anything strictly younger than the mispredicted branch is wrong-path.
            for (int i = 0; i < DEPTH; i++)
                kill[s][i] = bus.mispredict &&
                             (age_of(payload_q[s][i].rob_tag, bus.rob_head) > mp_age);
            if (count_q[s] != '0) begin
                pop_inv[s] = !valid_q[s][rd_ptr_q[s]];
                cand[s]    = valid_q[s][rd_ptr_q[s]] && !kill[s][rd_ptr_q[s]];
            end
        end

`ifdef CDB_OLDEST_FIRST_EN
        best_age = '1;
        for (int s = 0; s < NSRC; s++) begin
            if (cand[s] && (!grant_any ||
                            age_of(head_res[s].rob_tag, bus.rob_head) < best_age)) begin
                grant_any = 1'b1;
                grant_src = 2'(s);
                best_age  = age_of(head_res[s].rob_tag, bus.rob_head);
            end
        end
`else
        rr_idx = last_grant_q;
        for (int k = 0; k < NSRC; k++) begin
            rr_idx = (rr_idx == SRC_MEM) ? SRC_ALU : rr_idx + 2'd1;
            if (!grant_any && cand[rr_idx]) begin
                grant_any = 1'b1;
                grant_src = rr_idx;
            end
        end
`endif

        for (int s = 0; s < NSRC; s++) begin
            deq[s] = pop_inv[s] || (grant_any && grant_src == 2'(s));
            // A wrong-path result arriving in the mispredict cycle is simply not written.
            if (in_valid[s] && !(bus.mispredict &&
                    (age_of(in_res[s].rob_tag, bus.rob_head) > mp_age))) begin
                if (count_q[s] != FULL_CNT || deq[s])
                    accept[s] = 1'b1;
                else
                    ovf_hit = 1'b1;
            end
            count_nxt[s] = count_q[s] + CNT_W'(accept[s]) - CNT_W'(deq[s]);

            valid_nxt[s] = valid_q[s] & ~kill[s];
            if (deq[s])
                valid_nxt[s][rd_ptr_q[s]] = 1'b0;
            if (accept[s])
                valid_nxt[s][wr_ptr_q[s]] = 1'b1;
        end
    end

    // NOTE: payload slots carry no reset; occupancy is tracked by the reset valid bits and counts.
    always_ff @(posedge clk) begin
        for (int s = 0; s < NSRC; s++)
            if (accept[s])
                payload_q[s][wr_ptr_q[s]] <= in_res[s];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NSRC; s++) begin
                valid_q[s]  <= '0;
                rd_ptr_q[s] <= '0;
                wr_ptr_q[s] <= '0;
                count_q[s]  <= '0;
            end
            full_q       <= '0;
            last_grant_q <= SRC_MEM;
            cdb_valid_q  <= 1'b0;
            cdb_res_q    <= '0;
            cdb_src_q    <= SRC_ALU;
            overflow_q   <= 1'b0;
        end else begin
            for (int s = 0; s < NSRC; s++) begin
                valid_q[s]  <= valid_nxt[s];
                rd_ptr_q[s] <= rd_ptr_q[s] + PTR_W'(deq[s]);
                wr_ptr_q[s] <= wr_ptr_q[s] + PTR_W'(accept[s]);
                count_q[s]  <= count_nxt[s];
                full_q[s]   <= (count_nxt[s] == FULL_CNT);
            end
            cdb_valid_q <= grant_any;
            if (grant_any) begin
                cdb_res_q    <= head_res[grant_src];
                cdb_src_q    <= grant_src;
                last_grant_q <= grant_src;
            end
            overflow_q <= overflow_q | ovf_hit;
        end
    end

    assign bus.alu_full    = full_q[0];
    assign bus.b_full      = full_q[1];
    assign bus.mem_full    = full_q[2];
    assign bus.cdb_valid   = cdb_valid_q;
    assign bus.cdb_rob_tag = cdb_res_q.rob_tag;
    assign bus.cdb_pd      = cdb_res_q.pd;
    assign bus.cdb_data    = cdb_res_q.data;
    assign bus.cdb_src     = cdb_src_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter: latency, arbitration order, squash,
// wrap-around ages, fill/overflow and asynchronous reset.
module tb_cdb_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;
    int   fails  = 0;
    int   mem_seen;
    logic bad_seen;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.ROB_W(5), .PREG_W(7)) bus ();

    cdb_arbiter #(.DEPTH(4), .ROB_W(5), .PREG_W(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        bus.alu_valid  = 1'b0;
        bus.b_valid    = 1'b0;
        bus.mem_valid  = 1'b0;
        bus.mispredict = 1'b0;
    endtask

    task automatic drive(input int src, input logic [4:0] tag, input logic [6:0] pd,
                         input logic [31:0] data);
        case (src)
            0: begin bus.alu_valid = 1'b1; bus.alu_rob_tag = tag; bus.alu_pd = pd; bus.alu_data = data; end
            1: begin bus.b_valid   = 1'b1; bus.b_rob_tag   = tag; bus.b_pd   = pd; bus.b_data   = data; end
            default: begin bus.mem_valid = 1'b1; bus.mem_rob_tag = tag; bus.mem_pd = pd; bus.mem_data = data; end
        endcase
    endtask

    task automatic do_reset();
        clear();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Five cycles of all three FUs completing; round-robin leaves mem and branch full.
    task automatic fill5();
        for (int c = 0; c < 5; c++) begin
            drive(0, 5'(c),      7'(c),      32'h100 + c);
            drive(1, 5'(8 + c),  7'(8 + c),  32'h200 + c);
            drive(2, 5'(16 + c), 7'(16 + c), 32'h300 + c);
            tick();
        end
        clear();
    endtask

    initial begin
        clear();
        bus.alu_rob_tag = '0; bus.alu_pd = '0; bus.alu_data = '0;
        bus.b_rob_tag   = '0; bus.b_pd   = '0; bus.b_data   = '0;
        bus.mem_rob_tag = '0; bus.mem_pd = '0; bus.mem_data = '0;
        bus.rob_head    = '0;
        bus.mispredict_tag = '0;

        // Reset state
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_cdb_valid", 32'(bus.cdb_valid), 0);
        chk("rst_cdb_tag",   32'(bus.cdb_rob_tag), 0);
        chk("rst_cdb_pd",    32'(bus.cdb_pd), 0);
        chk("rst_cdb_data",  bus.cdb_data, 0);
        chk("rst_cdb_src",   32'(bus.cdb_src), 0);
        chk("rst_full",      32'({bus.alu_full, bus.b_full, bus.mem_full}), 0);
        chk("rst_overflow",  32'(bus.overflow), 0);
        reset = 1'b0;

        // Two-cycle latency from ALU
        drive(0, 5'd3, 7'd10, 32'hDEADBEEF);
        tick();
        clear();
        tick();
        chk("lat_valid", 32'(bus.cdb_valid), 1);
        chk("lat_tag",   32'(bus.cdb_rob_tag), 3);
        chk("lat_pd",    32'(bus.cdb_pd), 10);
        chk("lat_data",  bus.cdb_data, 32'hDEADBEEF);
        chk("lat_src",   32'(bus.cdb_src), 0);
        tick();
        chk("lat_idle",  32'(bus.cdb_valid), 0);
        chk("lat_hold",  bus.cdb_data, 32'hDEADBEEF);

        // All three in the same cycle
        do_reset();
        bus.rob_head = 5'd6;
        drive(0, 5'd5, 7'd50, 32'hA5);
        drive(1, 5'd6, 7'd60, 32'hB6);
        drive(2, 5'd7, 7'd70, 32'hC7);
        tick();
        clear();
        tick();
`ifdef CDB_OLDEST_FIRST_EN
        chk("ord0_src", 32'(bus.cdb_src), 1);
        chk("ord0_tag", 32'(bus.cdb_rob_tag), 6);
        tick();
        chk("ord1_src", 32'(bus.cdb_src), 2);
        chk("ord1_tag", 32'(bus.cdb_rob_tag), 7);
        tick();
        chk("ord2_src", 32'(bus.cdb_src), 0);
        chk("ord2_tag", 32'(bus.cdb_rob_tag), 5);
`else
        chk("ord0_src", 32'(bus.cdb_src), 0);
        chk("ord0_tag", 32'(bus.cdb_rob_tag), 5);
        tick();
        chk("ord1_src", 32'(bus.cdb_src), 1);
        chk("ord1_tag", 32'(bus.cdb_rob_tag), 6);
        tick();
        chk("ord2_src", 32'(bus.cdb_src), 2);
        chk("ord2_tag", 32'(bus.cdb_rob_tag), 7);
`endif
        chk("ord2_valid", 32'(bus.cdb_valid), 1);
        tick();
        chk("ord_idle", 32'(bus.cdb_valid), 0);

        // Mispredict squashes queued tag 6 and an incoming mem tag 9
        do_reset();
        bus.rob_head = 5'd0;
        drive(0, 5'd2, 7'd2, 32'h22);
        tick();
        drive(0, 5'd4, 7'd4, 32'h44);
        tick();
        chk("sq_tag2", 32'(bus.cdb_rob_tag), 2);
        drive(0, 5'd6, 7'd6, 32'h66);
        tick();
        chk("sq_tag4", 32'(bus.cdb_rob_tag), 4);
        chk("sq_tag4_valid", 32'(bus.cdb_valid), 1);
        clear();
        bus.mispredict = 1'b1;
        bus.mispredict_tag = 5'd4;
        drive(2, 5'd9, 7'd9, 32'h99);
        tick();
        clear();
        chk("sq_no_grant", 32'(bus.cdb_valid), 0);
        chk("sq_hold_tag", 32'(bus.cdb_rob_tag), 4);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("sq_quiet", 32'(bus.cdb_valid), 0);
        end
        chk("sq_full", 32'({bus.alu_full, bus.b_full, bus.mem_full}), 0);

        // Wrap-around ages: head 30, branch 31 kept, tags 0 and 29 squashed
        do_reset();
        bus.rob_head = 5'd30;
        drive(0, 5'd0,  7'd1, 32'h1000);
        drive(1, 5'd31, 7'd2, 32'h2000);
        drive(2, 5'd29, 7'd3, 32'h3000);
        tick();
        clear();
        bus.mispredict = 1'b1;
        bus.mispredict_tag = 5'd31;
        tick();
        clear();
        chk("wrap_valid", 32'(bus.cdb_valid), 1);
        chk("wrap_tag",   32'(bus.cdb_rob_tag), 31);
        chk("wrap_src",   32'(bus.cdb_src), 1);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("wrap_quiet", 32'(bus.cdb_valid), 0);
        end

        // Fill mem to DEPTH, then one more with no dequeue
        do_reset();
        bus.rob_head = 5'd0;
        fill5();
        chk("fill_mem_full", 32'(bus.mem_full), 1);
        chk("fill_b_full",   32'(bus.b_full), 1);
        chk("fill_alu_full", 32'(bus.alu_full), 0);
`ifndef CDB_OLDEST_FIRST_EN
        chk("fill_no_ovf",   32'(bus.overflow), 0);
`endif
        drive(2, 5'd21, 7'd21, 32'h3FF);
        tick();
        clear();
        chk("ovf_set",      32'(bus.overflow), 1);
        chk("ovf_mem_full", 32'(bus.mem_full), 1);
        mem_seen = 0;
        bad_seen = 1'b0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (bus.cdb_valid && bus.cdb_src == 2'd2) mem_seen++;
            if (bus.cdb_valid && bus.cdb_rob_tag == 5'd21) bad_seen = 1'b1;
        end
        chk("ovf_mem_count", 32'(mem_seen), 4);
        chk("ovf_dropped",   32'(bad_seen), 0);
        chk("ovf_sticky",    32'(bus.overflow), 1);
        chk("ovf_drained",   32'({bus.alu_full, bus.b_full, bus.mem_full}), 0);

        // Asynchronous reset mid-broadcast with full queues
        do_reset();
        fill5();
        chk("ar_pre_valid", 32'(bus.cdb_valid), 1);
        chk("ar_pre_full",  32'(bus.mem_full), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid",    32'(bus.cdb_valid), 0);
        chk("ar_full",     32'({bus.alu_full, bus.b_full, bus.mem_full}), 0);
        chk("ar_overflow", 32'(bus.overflow), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("ar_no_stale", 32'(bus.cdb_valid), 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
